// File: rtl/fetch_pc_queue_pkg.sv
// fetch_pc_queue_pkg: shared types for the fetch PC generator and its instruction queue
package fetch_pc_queue_pkg;
    localparam int XLEN = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            comp;
    } fetch_entry_t;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_e;
endpackage

// File: rtl/fetch_pc_queue_fifo.sv
// fetch_fifo: generic synchronous FIFO with flush, full/empty flags and occupancy count
module fetch_fifo #(
    parameter type T = logic,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  T            data_i,
    output T            data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);
    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;
    assign full_o  = r_count == (AW+1)'(DEPTH);
    assign empty_o = r_count == '0;
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    // pointers and count; flush empties the queue in one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    // storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= data_i;
    end
endmodule

// File: rtl/fetch_pc_queue.sv
// fetch_pc_queue: fetch PC generator feeding a small instruction queue read by decode
module fetch_pc_queue
    import fetch_pc_queue_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [XLEN-1:0] UNC_BASE = 32'h2000_0000,
    parameter logic [XLEN-1:0] UNC_MASK = 32'hF000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            buff_req_valid_o,
    output logic            buff_req_ready_o,
    output logic [XLEN-1:0] buff_req_addr_o,
    output logic            buff_req_uncached_o,
    input  logic            buff_res_valid_i,
    input  logic [31:0]     buff_res_blk_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_comp_o,
    input  logic            inst_ready_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic            r_req;
    logic            w_redir;
    logic            w_accept;
    logic            w_comp;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    // next state, request handshake and the entry to push
    always_comb begin
        w_redir             = redirect_i && r_state != IDLE;
        w_state_nxt         = r_state == IDLE ? RUN : (w_redir ? FLUSH : RUN);
        buff_req_valid_o    = r_state == RUN;
        buff_req_ready_o    = r_state == RUN && w_count < CW'(DEPTH);
        buff_req_addr_o     = r_pc;
        buff_req_uncached_o = (r_pc & UNC_MASK) == UNC_BASE;
        w_comp              = buff_res_blk_i[1:0] != 2'b11;
        w_accept            = r_req && buff_res_valid_i && buff_req_ready_o && !w_redir;
        w_pop               = !w_empty && inst_ready_i && !w_redir;
        w_push_entry.pc     = r_pc;
        w_push_entry.instr  = w_comp ? {16'h0, buff_res_blk_i[15:0]} : buff_res_blk_i;
        w_push_entry.comp   = w_comp;
    end
    // state, PC and the registered copy of the request valid seen by the align buffer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pc    <= RESET_VECTOR;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= buff_req_valid_o;
            if (w_redir) r_pc <= redirect_pc_i & ~XLEN'(1);
            else if (w_accept) r_pc <= r_pc + (w_comp ? XLEN'(2) : XLEN'(4));
        end
    end
    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_accept),
        .pop_i   (w_pop),
        .flush_i (w_redir),
        .data_i  (w_push_entry),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );
    assign inst_valid_o = !w_empty && !(w_full && w_empty);
    assign inst_o       = w_head.instr;
    assign inst_pc_o    = w_head.pc;
    assign inst_comp_o  = w_head.comp;
endmodule

// File: doc/fetch_pc_queue.md
Name: fetch_pc_queue

Overview:
Fetch-PC generator and instruction queue sitting directly upstream of gray_align_buffer.
- Drives the halfword-aligned fetch address and consumes the 32-bit parcel pair returned.
- Classifies each returned instruction as compressed or full, advances the PC by 2 or 4, and pushes {pc, instr, comp} into a DEPTH-entry FIFO read by decode.
- Handles pipeline redirects by flushing the queue and restarting fetch.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, instruction queue entries (power of 2, >=2)
RESET_VECTOR, 32'h8000_0000, PC loaded on reset
UNC_BASE, 32'h2000_0000, base of uncached fetch region
UNC_MASK, 32'hF000_0000, mask applied to PC before compare with UNC_BASE

Ports:
clk_i  in  1  clock, all state on posedge
rst_i  in  1  reset, synchronous and active-high
redirect_i  in  1  flush queue and restart fetch at redirect_pc_i
redirect_pc_i  in  XLEN  redirect target; bit 0 ignored
buff_req_valid_o  out  1  fetch request valid (maps icache_req_t.valid)
buff_req_ready_o  out  1  core can accept a response (maps icache_req_t.ready)
buff_req_addr_o  out  XLEN  fetch address (maps icache_req_t.addr)
buff_req_uncached_o  out  1  (buff_req_addr_o & UNC_MASK) == UNC_BASE
buff_res_valid_i  in  1  align buffer response valid (gbuff_res_t.valid)
buff_res_blk_i  in  32  instruction bits, [15:0] = parcel at buff_req_addr_o
inst_valid_o  out  1  queue head valid
inst_o  out  32  head instruction; compressed entries zero-extended ({16'b0, parcel})
inst_pc_o  out  XLEN  head PC
inst_comp_o  out  1  head is a 16-bit instruction
inst_ready_i  in  1  decode pops the head when high with inst_valid_o

Behaviour:
State machine (state_q: IDLE, RUN, FLUSH):
- Reset -> IDLE. IDLE -> RUN unconditionally the next cycle.
- RUN -> FLUSH on redirect_i. FLUSH -> RUN unconditionally the next cycle.

Reset values:
- state IDLE; pc_q = RESET_VECTOR; count = 0; req_q = 0.
- buff_req_valid_o = 0; buff_req_ready_o = 0; inst_valid_o = 0.
- buff_req_addr_o = RESET_VECTOR.

Request and accept:
- buff_req_valid_o = (state == RUN).
- buff_req_ready_o = (state == RUN) && (count < DEPTH).
- buff_req_addr_o = pc_q; it changes only on accept or redirect.
- req_q <= buff_req_valid_o. This mirrors the align buffer's registered valid.
- accept = req_q && buff_res_valid_i && buff_req_ready_o && !redirect_i.
- Hit latency: 1 cycle after first valid. Back-to-back hits give one accept per cycle, since valid stays high and the new address is looked up combinationally.
- Miss: address is held stable, valid stays asserted, and the block waits an unbounded number of cycles for buff_res_valid_i.

On accept:
- comp = (buff_res_blk_i[1:0] != 2'b11).
- Push entry {pc_q, comp ? {16'b0, blk[15:0]} : blk, comp}.
- pc_q <= pc_q + (comp ? 2 : 4), XLEN-bit wrap-around with no flag.

Queue full:
- Ready is deasserted, so the align buffer withholds valid.
- PC does not advance and no entry is lost.
- Fetch resumes the cycle after a pop makes count < DEPTH.

Pop and simultaneous events:
- Pop when inst_valid_o && inst_ready_i.
- Push and pop in the same cycle keep count unchanged. This is legal at count == DEPTH only if ready was already high, which cannot happen. Full therefore blocks the push.

Redirect (any state except IDLE):
- Same cycle: accept suppressed. Next cycle: count = 0, inst_valid_o = 0, pc_q = {redirect_pc_i[XLEN-1:1], 1'b0}, state FLUSH.
- FLUSH drives valid low for one cycle. This clears the buffer's registered valid and cancels any outstanding refill request, so no stale response can be accepted.
- Redirect wins over a simultaneous pop or accept.
- A redirect in FLUSH reloads pc_q and stays one more FLUSH cycle.

Reset mid-miss: everything returns to reset values; buffer state is untouched.

FIFO ordering:
- Head outputs are registered from FIFO storage.
- Pointers are log2(DEPTH) bits and wrap naturally.
- count is log2(DEPTH)+1 bits.

Decomposition:
- tcore_param additions: FETCH_QUEUE_DEPTH, typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] instr; logic comp;}, and fetch_state_e {IDLE, RUN, FLUSH}.
- One sub-module, fetch_fifo: generic synchronous FIFO parameterized on entry type and DEPTH, with push, pop, flush, full, empty and count.
- The PC/FSM logic stays in fetch_pc_queue.

Test Plan:
- Reset, all hits, blk = 32'h0000_0013 every cycle -> first valid at cycle 1 after IDLE; addrs 0x80000000, 0x80000004, 0x80000008; inst_comp_o = 0, one push/cycle.
- Compressed stream: 32'h4501_4501 at 0x80000000 -> entry comp = 1, inst_o = 32'h0000_4501; next addr 0x80000002, then 0x80000004.
- Unaligned 32-bit at 0x80000006 (blk 32'h0010_0093), miss 5 cycles -> addr held 5 cycles, single push {0x80000006, 32'h0010_0093, 0}, next addr 0x8000000A.
- inst_ready_i = 0 for 10 cycles, DEPTH = 4 -> exactly 4 entries, ready low, pc frozen. Raise inst_ready_i -> pops in order and fetch resumes the cycle after the first pop.
- redirect_i with pc 0x80000101 while a miss is pending and the queue holds 3 entries -> next cycle inst_valid_o = 0, one FLUSH cycle with valid low, then addr 0x80000100. A buff_res_valid_i during FLUSH is not accepted.
- Wrap: pc 0xFFFF_FFFE with a compressed instruction -> next addr 0x0000_0000; rst_i asserted mid-miss -> addr RESET_VECTOR and count 0 next cycle.
